// File: rtl/icache_if.sv
// Fetch-side and backing-memory signals of the direct-mapped instruction cache.
// The cache takes the slave modport; the fetch stage / memory model takes the master modport.
interface icache_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] addr;
    logic              read_en;
    logic [31:0]       data;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [31:0]       mem_data;

    modport master (
        output addr, read_en, mem_valid, mem_data,
        input  data, stall, mem_req, mem_addr
    );

    modport slave (
        input  addr, read_en, mem_valid, mem_data,
        output data, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with word-serial line refill.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.
//
// state  | meaning
// IDLE   | combinational lookup; hit returns word, miss latches line and starts refill
// REFILL | request words base+4*cnt in ascending order until the line is complete
module icache_dm #(
    parameter int ADDR_W     = 64,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic        clk,
    input  logic        reset,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int OFF    = WOFF_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFF - IDX_W;
    localparam logic [WOFF_W-1:0] CNT_LAST = WOFF_W'(LINE_WORDS - 1);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state, state_next;

    logic [31:0]       data_mem [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_idx;
    logic [WOFF_W-1:0] cnt;

    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  lk_idx;
    logic [WOFF_W-1:0] lk_off;
    logic              lk_match;

    logic        hit;
    logic        miss_start;
    logic        fill_we;
    logic        fill_last;
    logic        stall;
    logic [31:0] data;

    // Byte-lane bits of the fetch address carry no information for word fetches.
    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = bus.addr[1:0];

    assign lk_tag   = bus.addr[ADDR_W-1 -: TAG_W];
    assign lk_idx   = bus.addr[OFF +: IDX_W];
    assign lk_off   = bus.addr[2 +: WOFF_W];
    assign lk_match = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        hit        = 1'b0;
        miss_start = 1'b0;
        fill_we    = 1'b0;
        fill_last  = 1'b0;
        stall      = 1'b0;
        data       = 32'h0;
        case (state)
            IDLE: begin
                if (bus.read_en) begin
                    if (lk_match) begin
                        hit  = 1'b1;
                        data = data_mem[lk_idx][lk_off];
                    end else begin
                        stall      = 1'b1;
                        miss_start = 1'b1;
                        state_next = REFILL;
                    end
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (bus.mem_valid) begin
                    fill_we = 1'b1;
                    if (cnt == CNT_LAST) begin
                        fill_last  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // cnt wraps back to zero on the last word since LINE_WORDS is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag <= '0;
            r_idx <= '0;
            cnt   <= '0;
        end else if (miss_start) begin
            r_tag <= lk_tag;
            r_idx <= lk_idx;
            cnt   <= '0;
        end else if (fill_we) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[r_idx][cnt] <= bus.mem_data;
        end
        if (fill_last) begin
            tag_mem[r_idx] <= r_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (fill_last) begin
            valid[r_idx] <= 1'b1;
        end
    end

    assign bus.stall    = stall;
    assign bus.data     = data;
    assign bus.mem_req  = (state == REFILL);
    assign bus.mem_addr = (state == REFILL) ? {r_tag, r_idx, cnt, 2'b00} : '0;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/icache_dm.md
# icache_dm

Parametrised direct-mapped instruction cache that replaces the flat, preloaded instruction ROM in the fetch stage. It keeps the same fetch-side contract (`addr`, `read_en`, `data`, `stall`) and adds a tag/valid array, a multi-word line refill engine and a simple word-serial backing-memory port. On a miss, fetch stalls until the line is filled.

## Interface
Parameters:
- `ADDR_W`, 64: width of fetch and memory addresses.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, at least 2.
- `NUM_LINES`, 64: lines in the cache; power of two, at least 2.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `reset`, input, 1: synchronous, active-high.
- `addr`, input, ADDR_W: fetch byte address; `addr[1:0]` ignored.
- `read_en`, input, 1: fetch request this cycle.
- `data`, output, 32: instruction word, big-endian (byte at lowest address in bits 31:24).
- `stall`, output, 1: fetch must hold `addr` and retry.
- `mem_req`, output, 1: refill word request.
- `mem_addr`, output, ADDR_W: word-aligned address of the requested word.
- `mem_valid`, input, 1: `mem_data` holds the word for the current `mem_addr`.
- `mem_data`, input, 32: refill word, same byte order as `data`.
- `hit_count`, `miss_count`, output, 32: present only with `ICACHE_STATS_EN`.

## Operation
- Address split: offset = `addr[OFF-1:2]`, where OFF = log2(LINE_WORDS)+2. Index = next log2(NUM_LINES) bits. Tag = remaining upper bits.
- Storage: data array of NUM_LINES×LINE_WORDS words, tag array, valid bit per line.
- FSM states are IDLE and REFILL. A 0..LINE_WORDS-1 word counter `cnt` tracks refill progress.
- IDLE:
  - hit = `read_en` & valid[index] & (tag match).
  - On hit: `stall`=0 and `data` = stored word, both combinational in the same cycle.
  - On miss with `read_en`=1: `stall`=1. Latch line base (addr with offset cleared), latch tag and index, `cnt`←0, go to REFILL.
  - When `read_en`=0: `stall`=0 and `data`=0.
- REFILL:
  - `mem_req`=1 and `mem_addr` = base + 4·cnt. `stall`=1 regardless of `addr`/`read_en`. `data`=0.
  - On each `mem_valid`: write `mem_data` to word `cnt`, then `cnt`++.
  - On `mem_valid` with `cnt`=LINE_WORDS-1: write tag, set valid, go to IDLE.
  - `mem_valid` is ignored in IDLE.
- Words always fill in ascending order from the line base; there is no critical-word-first.
- `addr` changing during REFILL does not affect the latched refill. The new address is looked up in IDLE after the refill completes.
- A refill replaces the indexed line unconditionally; there is no write path from fetch.

## Timing
- Hit latency: 0 cycles (combinational from `addr`).
- Miss penalty: 1 + (number of cycles until the LINE_WORDS `mem_valid` pulses arrive). The lookup hits the cycle after the last word is written.
- Back-to-back `mem_valid` is accepted every cycle; gaps are allowed with no limit.
- `mem_req` and `mem_addr` are registered-state outputs, stable for the whole wait for each word.
- Reset values: state IDLE, `cnt`=0, all valid bits 0, `mem_req`=0, `mem_addr`=0, counters 0. After reset `stall` is combinational: 1 only if `read_en` is asserted and misses.
- Reset mid-refill: the partial line stays invalid and `mem_req` drops in the cycle after the reset edge. Any `mem_valid` arriving after that is ignored.

## Configuration
- `ICACHE_STATS_EN`: when defined, adds `hit_count` and `miss_count` ports.
  - `hit_count` increments in every IDLE cycle with a hit.
  - `miss_count` increments on every IDLE→REFILL transition.
  - Both saturate at 0xFFFFFFFF and clear on `reset`.
- When the macro is undefined, the ports and counters do not exist and the cache behaves identically otherwise.

## Test plan
All scenarios use defaults: LINE_WORDS=4, NUM_LINES=64.
- Cold miss: after reset, `read_en`=1, `addr`=0x100 → `stall`=1. `mem_addr` steps 0x100, 0x104, 0x108, 0x10C on each `mem_valid`. The cycle after the last word, `stall`=0 and `data` = word given for 0x100.
- Hit: then `addr`=0x108 → `stall`=0 same cycle, `data` = 0x108 word, `mem_req` stays 0.
- Conflict: `addr`=0x500 (index 16, tag 1) → miss and refill 0x500–0x50C. A following `addr`=0x100 misses again.
- Slow memory: 3 idle cycles between `mem_valid` pulses → `stall` held throughout, `mem_addr` advances only on `mem_valid`, refill completes after 4 pulses.
- Reset mid-refill: assert `reset` after 2 of 4 words → `mem_req`=0 the next cycle. `addr`=0x100 then misses and refills from 0x100.
- Stats (`ICACHE_STATS_EN`): after the cold-miss and hit scenarios → `miss_count`=1, `hit_count`=2 (post-refill 0x100 plus 0x108).
